// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster timing generator with a pixel enable.
// Sync, blank, raw position and line/frame strobes are registered from the
// current raster position, and then the counters advance. Output latency is
// one pixel_clock cycle.
// Optional feature: define VGA_TIMING_FRAME_CNT_EN to build the 16-bit
// completed-frame counter. Without it, frame_count is tied to zero.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int H_POL    = 0,
  parameter int V_POL    = 0,
  localparam int unsigned CNT_W = 11,
  localparam int unsigned FC_W  = 16
) (
  input  logic             pixel_clock,
  input  logic             reset_n,
  input  logic             ce,
  output logic             h_synch,
  output logic             v_synch,
  output logic             blank,
  output logic [CNT_W-1:0] pixel_x,
  output logic [CNT_W-1:0] pixel_y,
  output logic             line_start,
  output logic             frame_start,
  output logic [FC_W-1:0]  frame_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT_END  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_END  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START   = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END     = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START   = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END     = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic             H_POL_B    = 1'(H_POL);
  localparam logic             V_POL_B    = 1'(V_POL);

  // The raster totals must fit in the 11-bit counters.
  if (H_TOTAL > 2047 || V_TOTAL > 2047) begin : g_total_check
    $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed 2047");
  end

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic [CNT_W-1:0] h_nxt;
  logic [CNT_W-1:0] v_nxt;
  logic             h_wrap;
  logic             frame_wrap;
  logic             blank_d;
  logic             hs_d;
  logic             vs_d;

  // Next raster position and decode of the current position.
  always_comb begin
    h_wrap     = (h_cnt == H_LAST);
    frame_wrap = h_wrap && (v_cnt == V_LAST);
    h_nxt      = h_wrap ? '0 : h_cnt + CNT_W'(1);
    v_nxt      = v_cnt;
    if (h_wrap) begin
      v_nxt = (v_cnt == V_LAST) ? '0 : v_cnt + CNT_W'(1);
    end
    blank_d = (h_cnt >= H_ACT_END) || (v_cnt >= V_ACT_END);
    hs_d    = ((h_cnt >= HS_START) && (h_cnt < HS_END)) ? H_POL_B : ~H_POL_B;
    vs_d    = ((v_cnt >= VS_START) && (v_cnt < VS_END)) ? V_POL_B : ~V_POL_B;
  end

  // Raster counters, advanced only on enabled pixels.
  always_ff @(posedge pixel_clock or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (ce) begin
      h_cnt <= h_nxt;
      v_cnt <= v_nxt;
    end
  end

  // Registered outputs. Strobes last a single clock whatever ce does next.
  always_ff @(posedge pixel_clock or negedge reset_n) begin
    if (!reset_n) begin
      h_synch     <= ~H_POL_B;
      v_synch     <= ~V_POL_B;
      blank       <= 1'b1;
      pixel_x     <= '0;
      pixel_y     <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (ce) begin
        h_synch     <= hs_d;
        v_synch     <= vs_d;
        blank       <= blank_d;
        pixel_x     <= h_cnt;
        pixel_y     <= v_cnt;
        line_start  <= (h_cnt == '0);
        frame_start <= (h_cnt == '0) && (v_cnt == '0);
      end
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [FC_W-1:0] frame_cnt_q;

  // Completed frames, counted on the edge that wraps the raster to (0,0).
  always_ff @(posedge pixel_clock or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt_q <= '0;
    end else if (ce && frame_wrap) begin
      frame_cnt_q <= frame_cnt_q + FC_W'(1);
    end
  end

  assign frame_count = frame_cnt_q;
`else
  logic unused_frame_wrap;
  assign unused_frame_wrap = frame_wrap;
  assign frame_count       = '0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: checks vga_timing_gen against a linear-position raster
// model. The raster is reduced so that whole frames stay short.
module tb_vga_timing_gen;

  localparam int HA = 20, HFP = 3, HS = 5, HBP = 4;
  localparam int VA = 10, VFP = 2, VS = 3, VBP = 2;
  localparam int HP = 1, VP = 0;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int FRAME = HT * VT;

  logic        pixel_clock = 1'b0;
  logic        reset_n;
  logic        ce;
  logic        h_synch, v_synch, blank, line_start, frame_start;
  logic [10:0] pixel_x, pixel_y;
  logic [15:0] frame_count;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .H_POL(HP), .V_POL(VP)
  ) dut (
    .pixel_clock(pixel_clock),
    .reset_n    (reset_n),
    .ce         (ce),
    .h_synch    (h_synch),
    .v_synch    (v_synch),
    .blank      (blank),
    .pixel_x    (pixel_x),
    .pixel_y    (pixel_y),
    .line_start (line_start),
    .frame_start(frame_start),
    .frame_count(frame_count)
  );

  always #5 pixel_clock = ~pixel_clock;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Model: the raster is a single position index within the frame.
  int          pos;
  logic        m_hs, m_vs, m_blank, m_ls, m_fs;
  logic [10:0] m_x, m_y;
  logic [15:0] m_fc;

  logic [42:0] act_vec;
  assign act_vec = {h_synch, v_synch, blank, pixel_x, pixel_y, line_start, frame_start, frame_count};

  function automatic logic [42:0] exp_vec();
    return {m_hs, m_vs, m_blank, m_x, m_y, m_ls, m_fs, m_fc};
  endfunction

  task automatic model_reset();
    pos     = 0;
    m_hs    = (HP == 0);
    m_vs    = (VP == 0);
    m_blank = 1'b1;
    m_x     = '0;
    m_y     = '0;
    m_ls    = 1'b0;
    m_fs    = 1'b0;
    m_fc    = '0;
  endtask

  task automatic model_step(input logic c);
    int x, y;
    if (c) begin
      x       = pos % HT;
      y       = pos / HT;
      m_x     = 11'(x);
      m_y     = 11'(y);
      m_blank = (x >= HA) || (y >= VA);
      m_hs    = (x >= HA + HFP && x < HA + HFP + HS) ? (HP != 0) : (HP == 0);
      m_vs    = (y >= VA + VFP && y < VA + VFP + VS) ? (VP != 0) : (VP == 0);
      m_ls    = (x == 0);
      m_fs    = (pos == 0);
`ifdef VGA_TIMING_FRAME_CNT_EN
      if (pos == FRAME - 1) m_fc = m_fc + 16'd1;
`endif
      pos = (pos + 1) % FRAME;
    end else begin
      m_ls = 1'b0;
      m_fs = 1'b0;
    end
  endtask

  task automatic tick(input logic c);
    ce = c;
    @(posedge pixel_clock);
    #1;
    model_step(c);
    cyc++;
  endtask

  task automatic do_reset();
    ce      = 1'b0;
    reset_n = 1'b0;
    @(posedge pixel_clock);
    #1;
    model_reset();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    ce      = 1'b1;
    repeat (3) @(posedge pixel_clock);
    #1;
    model_reset();
    n_tests++;
    if (act_vec !== exp_vec()) begin
      n_fail++;
      $display("FAIL reset_hold: got %h expected %h", act_vec, exp_vec());
    end
    reset_n = 1'b1;
    tick(1'b1);
    n_tests++;
    if ({blank, line_start, frame_start, pixel_x, pixel_y} !== {1'b0, 1'b1, 1'b1, 11'd0, 11'd0}) begin
      n_fail++;
      $display("FAIL first_after_reset: got blank=%b ls=%b fs=%b x=%0d y=%0d expected 0 1 1 0 0",
               blank, line_start, frame_start, pixel_x, pixel_y);
    end
  endtask

  task automatic test_active_line();
    do_reset();
    for (int i = 1; i <= HT + 1; i++) begin
      tick(1'b1);
      n_tests++;
      if (act_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL active_line cycle %0d: got %h expected %h", i, act_vec, exp_vec());
      end
      if (i == 1) begin
        n_tests++;
        if ({blank, pixel_x, frame_start} !== {1'b0, 11'd0, 1'b1}) begin
          n_fail++;
          $display("FAIL active_first: got blank=%b x=%0d fs=%b expected 0 0 1", blank, pixel_x, frame_start);
        end
      end
      if (i == HA + 1) begin
        n_tests++;
        if ({blank, pixel_x} !== {1'b1, 11'(HA)}) begin
          n_fail++;
          $display("FAIL active_end: got blank=%b x=%0d expected 1 %0d", blank, pixel_x, HA);
        end
      end
    end
  endtask

  task automatic test_sync();
    int hs_cnt = 0, hs_first = -1, vs_cnt = 0, vs_first_x = -1, vs_first_y = -1;
    do_reset();
    for (int i = 0; i < FRAME; i++) begin
      tick(1'b1);
      n_tests++;
      if (act_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL sync_frame cycle %0d: got %h expected %h", i, act_vec, exp_vec());
      end
      if (i < HT && h_synch === (HP != 0)) begin
        if (hs_first < 0) hs_first = int'(pixel_x);
        hs_cnt++;
      end
      if (v_synch === (VP != 0)) begin
        if (vs_first_x < 0) begin
          vs_first_x = int'(pixel_x);
          vs_first_y = int'(pixel_y);
        end
        vs_cnt++;
      end
    end
    n_tests++;
    if (hs_cnt != HS || hs_first != HA + HFP) begin
      n_fail++;
      $display("FAIL hsync_window: got width=%0d start=%0d expected %0d %0d", hs_cnt, hs_first, HS, HA + HFP);
    end
    n_tests++;
    if (vs_cnt != VS * HT || vs_first_x != 0 || vs_first_y != VA + VFP) begin
      n_fail++;
      $display("FAIL vsync_window: got clocks=%0d start=(%0d,%0d) expected %0d (0,%0d)",
               vs_cnt, vs_first_x, vs_first_y, VS * HT, VA + VFP);
    end
  endtask

  task automatic test_ce_random();
    for (int i = 0; i < 3 * FRAME; i++) begin
      tick(1'($urandom_range(0, 1)));
      n_tests++;
      if (act_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL ce_random cycle %0d ce=%b: got %h expected %h", i, ce, act_vec, exp_vec());
      end
    end
  endtask

  task automatic test_ce_toggle();
    int n_fs = 0, fs_a = -1, fs_b = -1;
    do_reset();
    for (int i = 1; i <= 4 * FRAME; i++) begin
      tick(1'(i % 2));
      n_tests++;
      if (act_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL ce_toggle cycle %0d: got %h expected %h", i, act_vec, exp_vec());
      end
      if (frame_start === 1'b1) begin
        if (n_fs == 0) fs_a = i;
        else if (n_fs == 1) fs_b = i;
        n_fs++;
      end
    end
    n_tests++;
    if (n_fs != 2 || fs_b - fs_a != 2 * FRAME) begin
      n_fail++;
      $display("FAIL ce_toggle_period: got pulses=%0d period=%0d expected 2 %0d", n_fs, fs_b - fs_a, 2 * FRAME);
    end
  endtask

  task automatic test_mid_reset();
    int target;
    do_reset();
    target = int'($urandom_range(2 * HT, FRAME - 2));
    for (int i = 0; i < target; i++) begin
      tick(1'b1);
      n_tests++;
      if (act_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL mid_run cycle %0d: got %h expected %h", i, act_vec, exp_vec());
      end
    end
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    n_tests++;
    if (act_vec !== exp_vec()) begin
      n_fail++;
      $display("FAIL mid_reset_async: got %h expected %h", act_vec, exp_vec());
    end
    ce = 1'b1;
    repeat (2) @(posedge pixel_clock);
    #1;
    n_tests++;
    if (act_vec !== exp_vec()) begin
      n_fail++;
      $display("FAIL mid_reset_hold: got %h expected %h", act_vec, exp_vec());
    end
    reset_n = 1'b1;
    tick(1'b1);
    n_tests++;
    if ({pixel_x, pixel_y, frame_start, line_start, blank} !== {11'd0, 11'd0, 1'b1, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL mid_reset_restart: got x=%0d y=%0d fs=%b ls=%b blank=%b expected 0 0 1 1 0",
               pixel_x, pixel_y, frame_start, line_start, blank);
    end
  endtask

  task automatic test_frame_count();
    logic [15:0] want;
`ifdef VGA_TIMING_FRAME_CNT_EN
    want = 16'd3;
`else
    want = 16'd0;
`endif
    do_reset();
    for (int i = 0; i < 3 * FRAME; i++) begin
      tick(1'b1);
      n_tests++;
      if (act_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL frame_run cycle %0d: got %h expected %h", i, act_vec, exp_vec());
      end
    end
    n_tests++;
    if (frame_count !== want) begin
      n_fail++;
      $display("FAIL frame_count: got %0d expected %0d", frame_count, want);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    ce      = 1'b0;
    model_reset();
    test_reset();
    test_active_line();
    test_sync();
    test_ce_random();
    test_ce_toggle();
    test_mid_reset();
    test_frame_count();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
